// File: rtl/requant_packer.sv
// Packs a stream of narrow requantized samples LSB-first into wide words and
// buffers completed words in a small FIFO toward a ready/valid consumer.
module requant_packer #(
   parameter int unsigned Sample_bits = 6,
   parameter int unsigned Word_bits   = 32,
   parameter int unsigned Fifo_depth  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [Sample_bits-1:0] data_in,
   input  logic                   data_valid_i,
   input  logic                   flush_i,
   output logic [Word_bits-1:0]   word_o,
   output logic                   word_valid_o,
   input  logic                   word_ready_i,
   output logic                   overflow_o,
   output logic [15:0]            word_cnt_o
);

   localparam int unsigned AccW  = Word_bits + Sample_bits;
   localparam int unsigned FillW = $clog2(AccW);
   localparam int unsigned PtrW  = (Fifo_depth > 1) ? $clog2(Fifo_depth) : 1;
   localparam int unsigned CntW  = PtrW + 1;

   logic [AccW-1:0]      acc_q, acc_d, acc_ext;
   logic [FillW-1:0]     fill_q, fill_d, fill_sum;
   logic                 pend_q, pend_d;
   logic                 push_req, push_en, pop, full;
   logic [Word_bits-1:0] push_word;

   logic [Word_bits-1:0] mem_q [Fifo_depth];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [Word_bits-1:0] head_d, word_q;
   logic                 valid_q, ovf_q;
   logic [15:0]          cnt_q;

   // Packer: merge sample at the fill offset, emit a word on overrun or flush
   always_comb begin
      acc_ext   = acc_q | (AccW'(data_in) << fill_q);
      fill_sum  = fill_q + FillW'(Sample_bits);
      acc_d     = acc_q;
      fill_d    = fill_q;
      pend_d    = pend_q;
      push_req  = 1'b0;
      push_word = '0;
      if (data_valid_i) begin
         if (flush_i) pend_d = 1'b1;
         if (fill_sum >= FillW'(Word_bits)) begin
            push_req  = 1'b1;
            push_word = acc_ext[Word_bits-1:0];
            acc_d     = acc_ext >> Word_bits;
            fill_d    = fill_sum - FillW'(Word_bits);
         end else begin
            acc_d  = acc_ext;
            fill_d = fill_sum;
         end
      end else if (flush_i || pend_q) begin
         pend_d = 1'b0;
         // Bits above fill are always zero, so the partial word is already padded
         if (fill_q != '0) begin
            push_req  = 1'b1;
            push_word = acc_q[Word_bits-1:0];
            acc_d     = '0;
            fill_d    = '0;
         end
      end
   end

   // FIFO control; head word is re-registered so outputs come straight from flops
   always_comb begin
      full     = (count_q == CntW'(Fifo_depth));
      pop      = valid_q && word_ready_i;
      push_en  = push_req && (!full || pop);
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q + CntW'(push_en) - CntW'(pop);
      head_d   = (push_en && (wr_ptr_q == rd_ptr_d)) ? push_word : mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q    <= '0;
         fill_q   <= '0;
         pend_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         word_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         for (int i = 0; i < Fifo_depth; i++) mem_q[i] <= '0;
      end else begin
         acc_q    <= acc_d;
         fill_q   <= fill_d;
         pend_q   <= pend_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         word_q   <= head_d;
         valid_q  <= (count_d != '0);
         if (push_en) begin
            mem_q[wr_ptr_q] <= push_word;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            cnt_q           <= cnt_q + 16'd1;
         end
         if (push_req && !push_en) ovf_q <= 1'b1;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = valid_q;
   assign overflow_o   = ovf_q;
   assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_requant_packer.sv
// Scoreboard bench for requant_packer: a bit-level packing model queues
// expected words; a monitor pops and compares every word the DUT hands off.
module tb_requant_packer;

   localparam int unsigned SB = 6;
   localparam int unsigned WB = 32;
   localparam int unsigned FD = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [SB-1:0] data_in = '0;
   logic          data_valid_i = 1'b0;
   logic          flush_i = 1'b0;
   logic [WB-1:0] word_o;
   logic          word_valid_o;
   logic          word_ready_i = 1'b0;
   logic          overflow_o;
   logic [15:0]   word_cnt_o;

   requant_packer #(.Sample_bits(SB), .Word_bits(WB), .Fifo_depth(FD)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_in(data_in), .data_valid_i(data_valid_i),
      .flush_i(flush_i), .word_o(word_o), .word_valid_o(word_valid_o),
      .word_ready_i(word_ready_i), .overflow_o(overflow_o), .word_cnt_o(word_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int            tests = 0;
   int            fails = 0;
   int            seen  = 0;
   logic [WB-1:0] last_word = '0;
   logic [WB-1:0] exp_q[$];

   // Reference packing model
   logic [63:0] m_acc  = '0;
   int          m_fill = 0;
   bit          m_pend = 0;
   bit          m_ovf  = 0;
   int          m_cnt  = 0;

   task automatic model_push(input logic [WB-1:0] w);
      if (exp_q.size() < FD) begin
         exp_q.push_back(w);
         m_cnt++;
      end else begin
         m_ovf = 1;
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_acc = '0; m_fill = 0; m_pend = 0; m_ovf = 0; m_cnt = 0;
   endtask

   task automatic step(input logic v, input logic [SB-1:0] d, input logic f);
      data_valid_i = v; data_in = d; flush_i = f;
      if (v) begin
         if (f) m_pend = 1;
         m_acc  = m_acc | (64'(d) << m_fill);
         m_fill = m_fill + SB;
         if (m_fill >= WB) begin
            model_push(m_acc[WB-1:0]);
            m_acc  = m_acc >> WB;
            m_fill = m_fill - WB;
         end
      end else if (f || m_pend) begin
         m_pend = 0;
         if (m_fill > 0) begin
            model_push(m_acc[WB-1:0]);
            m_acc = '0; m_fill = 0;
         end
      end
      @(posedge clk_i); #1;
      data_valid_i = 1'b0; flush_i = 1'b0; data_in = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   // Monitor: every accepted handoff must match the head of the scoreboard
   always @(negedge clk_i) begin
      if (rst_ni && word_valid_o && word_ready_i) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL handoff_unexpected got %h, none expected", word_o);
         end else begin
            logic [WB-1:0] e;
            e = exp_q.pop_front();
            if (word_o !== e) begin
               fails++;
               $display("FAIL handoff_word got %h expected %h", word_o, e);
            end
         end
         last_word = word_o;
         seen++;
      end
   end

   task automatic test_reset();
      #2;
      tests++;
      if ({word_valid_o, word_o, overflow_o, word_cnt_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got v=%b w=%h o=%b c=%h expected all zero",
                  word_valid_o, word_o, overflow_o, word_cnt_o);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      tests++;
      if (word_valid_o !== 1'b0 || word_cnt_o !== 16'd0) begin
         fails++;
         $display("FAIL reset_release got v=%b c=%h expected 0/0", word_valid_o, word_cnt_o);
      end
   endtask

   task automatic test_full_words();
      int s0;
      s0 = seen;
      word_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) step(1'b1, 6'h3F, 1'b0);
      idle(3);
      step(1'b0, '0, 1'b1);   // fill is zero, so this must not push
      idle(2);
      tests++;
      if (word_cnt_o !== 16'(m_cnt) || m_cnt != 3) begin
         fails++;
         $display("FAIL full_words_cnt got %0d expected 3 (model %0d)", word_cnt_o, m_cnt);
      end
      tests++;
      if (seen - s0 != 3) begin
         fails++;
         $display("FAIL full_words_seen got %0d expected 3", seen - s0);
      end
   endtask

   task automatic test_pattern();
      word_ready_i = 1'b1;
      for (int i = 1; i <= 6; i++) step(1'b1, SB'(i), 1'b0);
      idle(2);
      tests++;
      if (last_word !== 32'h85103081) begin
         fails++;
         $display("FAIL pattern_word got %h expected 85103081", last_word);
      end
      step(1'b0, '0, 1'b1);
      idle(2);
      tests++;
      if (last_word !== 32'h00000001) begin
         fails++;
         $display("FAIL pattern_residue got %h expected 00000001", last_word);
      end
   endtask

   task automatic test_flush();
      int c0;
      word_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b1, 6'h3F, 1'b0);
      tests++;
      if (word_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL flush_prevalid got %b expected 0", word_valid_o);
      end
      step(1'b0, '0, 1'b1);
      tests++;
      if (word_valid_o !== 1'b1 || word_o !== 32'h3FFFFFFF) begin
         fails++;
         $display("FAIL flush_word got v=%b w=%h expected 1/3fffffff", word_valid_o, word_o);
      end
      c0 = m_cnt;
      step(1'b0, '0, 1'b1);
      idle(2);
      tests++;
      if (word_cnt_o !== 16'(c0)) begin
         fails++;
         $display("FAIL flush_empty_noop got cnt %0d expected %0d", word_cnt_o, c0);
      end
      word_ready_i = 1'b1;
      idle(3);
   endtask

   task automatic test_flush_coincident();
      word_ready_i = 1'b1;
      step(1'b1, 6'h3F, 1'b0);
      step(1'b1, 6'h3F, 1'b0);
      step(1'b1, 6'h15, 1'b1);
      tests++;
      if (word_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL coincident_early got v=%b expected 0", word_valid_o);
      end
      step(1'b0, '0, 1'b0);
      tests++;
      if (word_valid_o !== 1'b1) begin
         fails++;
         $display("FAIL coincident_latency got v=%b expected 1", word_valid_o);
      end
      idle(2);
      tests++;
      if (last_word !== 32'h00015FFF || word_cnt_o !== 16'(m_cnt)) begin
         fails++;
         $display("FAIL coincident_word got %h cnt %0d expected 00015fff cnt %0d",
                  last_word, word_cnt_o, m_cnt);
      end
   endtask

   task automatic test_overflow();
      int c0;
      c0 = m_cnt;
      word_ready_i = 1'b0;
      for (int i = 0; i < 30; i++) step(1'b1, 6'h3F, 1'b0);
      idle(1);
      tests++;
      if (overflow_o !== 1'b1 || m_ovf != 1) begin
         fails++;
         $display("FAIL overflow_flag got %b expected 1", overflow_o);
      end
      tests++;
      if (word_cnt_o !== 16'(c0 + 4)) begin
         fails++;
         $display("FAIL overflow_cnt got %0d expected %0d", word_cnt_o, c0 + 4);
      end
      word_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         tests++;
         if (word_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL drain_valid beat %0d got %b expected 1", i, word_valid_o);
         end
      end
      @(negedge clk_i);
      tests++;
      if (word_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL drain_empty got %b expected 0", word_valid_o);
      end
      @(posedge clk_i); #1;
      step(1'b0, '0, 1'b1);
      idle(3);
   endtask

   task automatic test_reset_mid();
      int s0;
      word_ready_i = 1'b0;
      for (int i = 0; i < 14; i++) step(1'b1, 6'h3F, 1'b0);
      tests++;
      if (word_valid_o !== 1'b1) begin
         fails++;
         $display("FAIL midreset_buffered got v=%b expected 1", word_valid_o);
      end
      rst_ni = 1'b0;
      model_clear();
      #2;
      tests++;
      if ({word_valid_o, word_o, overflow_o, word_cnt_o} !== '0) begin
         fails++;
         $display("FAIL midreset_outputs got v=%b w=%h o=%b c=%h expected all zero",
                  word_valid_o, word_o, overflow_o, word_cnt_o);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      word_ready_i = 1'b1;
      s0 = seen;
      for (int i = 0; i < 16; i++) step(1'b1, 6'h3F, 1'b0);
      idle(3);
      tests++;
      if (word_cnt_o !== 16'd3 || seen - s0 != 3) begin
         fails++;
         $display("FAIL midreset_restart got cnt %0d seen %0d expected 3/3",
                  word_cnt_o, seen - s0);
      end
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_pattern();
      test_flush();
      test_flush_coincident();
      test_overflow();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_leftover got %0d words expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL timeout got no completion expected finish");
      $fatal(1);
   end

endmodule
